lock_sequencer: RTL

Sequencing controller for a rise-edge lock detector. It holds the detector in clear, releases it on `start`, and watches its `locked` output against a timeout. It retries a bounded number of times before declaring failure. Once locked, it supervises the rise-edge cadence and forces an automatic relock when edges stop.

---
 rtl/lock_sequencer_if.sv | 26 ++
 rtl/lock_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lock_sequencer_if.sv
// Control/status bundle between a lock sequencer and its supervisor.
// master drives requests and detector status, slave drives sequencing outputs.
interface lock_sequencer_if #(
  parameter int RW = 2
);
  logic          start;
  logic          abort;
  logic          locked;
  logic          rise_edge;
  logic          clear;
  logic          busy;
  logic          lock_ok;
  logic          lock_fail;
  logic          lost;
  logic [RW-1:0] retry_cnt;

  modport master (
    output start, abort, locked, rise_edge,
    input  clear, busy, lock_ok, lock_fail, lost, retry_cnt
  );

  modport slave (
    input  start, abort, locked, rise_edge,
    output clear, busy, lock_ok, lock_fail, lost, retry_cnt
  );
endinterface

// File: rtl/lock_sequencer.sv
// Acquisition and supervision FSM for a rise-edge lock detector:
// clear, wait with timeout and bounded retry, then edge-cadence watchdog.
module lock_sequencer #(
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int HOLD_CYCLES    = 256
) (
  input logic             clk,
  input logic             rst_n,
  lock_sequencer_if.slave bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(HOLD_CYCLES);

  localparam logic [CW-1:0] CLR_END = CW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_END = GW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_LOCKED,
    S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          clear_q, clear_d;
  logic          busy_q, busy_d;
  logic          ok_q, ok_d;
  logic          fail_q, fail_d;
  logic          lost_q, lost_d;
  logic          loss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ccnt_q  <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
      retry_q <= '0;
      clear_q <= 1'b1;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      retry_q <= retry_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      lost_q  <= lost_d;
    end
  end

  // Counters read zero whenever their state is not being held,
  // so every entry starts from 0 without a separate clear.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    ccnt_d  = '0;
    tmr_d   = '0;
    gap_d   = '0;
    loss    = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_FAIL: begin
          if (bus.start) begin
            state_d = S_CLEAR;
            retry_d = '0;
          end
        end
        S_CLEAR: begin
          if (ccnt_q == CLR_END) state_d = S_WAIT;
          else ccnt_d = ccnt_q + 1'b1;
        end
        S_WAIT: begin
          if (bus.locked) begin
            state_d = S_LOCKED;
          end else if (tmr_q == TMO_END) begin
            if (retry_q == RTY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_CLEAR;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!bus.locked || (gap_q == GAP_END && !bus.rise_edge)) begin
            loss    = 1'b1;
            state_d = S_CLEAR;
            retry_d = '0;
          end else if (!bus.rise_edge) begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    clear_d = 1'b0;
    busy_d  = 1'b0;
    ok_d    = 1'b0;
    fail_d  = 1'b0;
    lost_d  = loss;
    unique case (state_d)
      S_IDLE:   clear_d = 1'b1;
      S_CLEAR: begin
        clear_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_WAIT:   busy_d = 1'b1;
      S_LOCKED: begin
        busy_d = 1'b1;
        ok_d   = 1'b1;
      end
      S_FAIL: begin
        clear_d = 1'b1;
        fail_d  = 1'b1;
      end
      default:  clear_d = 1'b1;
    endcase
  end

  assign bus.clear     = clear_q;
  assign bus.busy      = busy_q;
  assign bus.lock_ok   = ok_q;
  assign bus.lock_fail = fail_q;
  assign bus.lost      = lost_q;
  assign bus.retry_cnt = retry_q;

endmodule
